// File: rtl/alu_result_fifo.sv
// Capture stage for ALU results: show-ahead FIFO with valid/ready handshake,
// sticky carry/overflow flags, saturating accumulator and drop counter.
module alu_result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_carry,
    input  logic                       in_over,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_carry,
    output logic                       out_over,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sticky_carry,
    output logic                       sticky_over,
    input  logic                       clr_sticky,
    output logic [ACC_W-1:0]           acc,
    output logic                       acc_sat,
    input  logic                       acc_clr,
    output logic [7:0]                 drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_W + 2;

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             sticky_carry_reg;
    logic             sticky_over_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             acc_sat_reg;
    logic [7:0]       drop_cnt_reg;

    logic             full;
    logic             push;
    logic             pop;
    logic [ACC_W:0]   sum;
    logic [EW-1:0]    head;

    assign full      = (count_reg == CW'(DEPTH));
    assign in_ready  = !rst && !full;
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // One extra bit catches the carry-out that triggers saturation.
    assign sum       = {1'b0, acc_reg} + (ACC_W + 1)'(in_data);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_over, in_carry, in_data};
        end
    end

    assign head      = mem[rd_ptr_reg];
    assign out_data  = head[DATA_W-1:0];
    assign out_carry = head[DATA_W];
    assign out_over  = head[DATA_W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // A push with a flag set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_carry_reg <= 1'b0;
            sticky_over_reg  <= 1'b0;
        end else if (clr_sticky) begin
            sticky_carry_reg <= push && in_carry;
            sticky_over_reg  <= push && in_over;
        end else begin
            sticky_carry_reg <= sticky_carry_reg || (push && in_carry);
            sticky_over_reg  <= sticky_over_reg || (push && in_over);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            acc_sat_reg <= 1'b0;
        end else if (acc_clr) begin
            acc_reg     <= '0;
            acc_sat_reg <= 1'b0;
        end else if (push && !acc_sat_reg) begin
            if (sum[ACC_W]) begin
                acc_reg     <= '1;
                acc_sat_reg <= 1'b1;
            end else begin
                acc_reg <= sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (in_valid && !in_ready && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign count        = count_reg;
    assign sticky_carry = sticky_carry_reg;
    assign sticky_over  = sticky_over_reg;
    assign acc          = acc_reg;
    assign acc_sat      = acc_sat_reg;
    assign drop_cnt     = drop_cnt_reg;

endmodule
